// File: rtl/event_pulse_array.sv
// event_pulse_array: per-channel synchroniser, glitch filter, edge-mode event pulse and sticky status with IRQ.
// Optional saturating per-channel event counters are built when EVENT_PULSE_CNT_EN is defined.
module event_pulse_array #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             in,
    input  logic [2*NUM_CH-1:0]           mode,
    input  logic [NUM_CH-1:0]             status_clr,
    input  logic [NUM_CH-1:0]             cnt_clr,
    output logic [NUM_CH-1:0]             rise_pulse,
    output logic [NUM_CH-1:0]             fall_pulse,
    output logic [NUM_CH-1:0]             event_pulse,
    output logic [NUM_CH-1:0]             level,
    output logic [NUM_CH-1:0]             status,
    output logic                          irq,
    output logic [CNT_WIDTH*NUM_CH-1:0]   event_cnt
);

    localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

    logic [NUM_CH-1:0] status_vec_s;
    logic              irq_r;

`ifndef EVENT_PULSE_CNT_EN
    logic              unused_cnt_clr_s;
    assign unused_cnt_clr_s = ^cnt_clr;
`endif

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_chain_r;
            logic                   sync_s;
            logic [7:0]             stab_cnt_r;
            logic [7:0]             stab_cnt_next_s;
            logic                   level_r;
            logic                   level_next_s;
            logic                   accept_s;
            logic                   rise_next_s;
            logic                   fall_next_s;
            logic                   event_next_s;
            logic                   rise_r;
            logic                   fall_r;
            logic                   event_r;
            logic                   status_r;
            logic                   status_next_s;

            // Synchroniser shift chain for the raw asynchronous input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_chain_r <= '0;
                end else begin
                    sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], in[c]};
                end
            end

            assign sync_s = sync_chain_r[SYNC_STAGES-1];

            // Stability filter: a new level is accepted only after persisting FILTER_CYCLES evaluations
            always_comb begin
                stab_cnt_next_s = 8'd0;
                level_next_s    = level_r;
                accept_s        = 1'b0;
                if (sync_s == level_r) begin
                    stab_cnt_next_s = 8'd0;
                end else if (stab_cnt_r == FILT_LAST) begin
                    stab_cnt_next_s = 8'd0;
                    level_next_s    = sync_s;
                    accept_s        = 1'b1;
                end else begin
                    stab_cnt_next_s = stab_cnt_r + 8'd1;
                end
            end

            // Edge decode, mode gating and sticky status (set beats clear)
            always_comb begin
                rise_next_s   = accept_s & sync_s;
                fall_next_s   = accept_s & ~sync_s;
                event_next_s  = (rise_next_s & mode[2*c]) | (fall_next_s & mode[2*c+1]);
                status_next_s = event_next_s | (status_r & ~status_clr[c]);
            end

            // Per-channel filter, level, pulse and status registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stab_cnt_r <= 8'd0;
                    level_r    <= 1'b0;
                    rise_r     <= 1'b0;
                    fall_r     <= 1'b0;
                    event_r    <= 1'b0;
                    status_r   <= 1'b0;
                end else begin
                    stab_cnt_r <= stab_cnt_next_s;
                    level_r    <= level_next_s;
                    rise_r     <= rise_next_s;
                    fall_r     <= fall_next_s;
                    event_r    <= event_next_s;
                    status_r   <= status_next_s;
                end
            end

            assign rise_pulse[c]   = rise_r;
            assign fall_pulse[c]   = fall_r;
            assign event_pulse[c]  = event_r;
            assign level[c]        = level_r;
            assign status[c]       = status_r;
            assign status_vec_s[c] = status_r;

`ifdef EVENT_PULSE_CNT_EN
            localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);
            logic [CNT_WIDTH-1:0] cnt_r;
            logic [CNT_WIDTH-1:0] cnt_next_s;

            // Saturating event counter; a clear coinciding with an event leaves a count of one
            always_comb begin
                cnt_next_s = cnt_r;
                if (cnt_clr[c]) begin
                    if (event_next_s) begin
                        cnt_next_s = CNT_ONE;
                    end else begin
                        cnt_next_s = '0;
                    end
                end else if (event_next_s && (cnt_r != '1)) begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end

            // Event counter register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_next_s;
                end
            end

            assign event_cnt[c*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
`else
            assign event_cnt[c*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
        end
    endgenerate

    // IRQ follows the registered status flags, so it trails a status change by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |status_vec_s;
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_event_pulse_array.sv
// Directed bench for event_pulse_array: a default instance (SYNC=2, FILTER=1) and a
// FILTER_CYCLES=4 / CNT_WIDTH=4 instance sharing clock and reset.
module tb_event_pulse_array;

`ifdef EVENT_PULSE_CNT_EN
    localparam int CNT_SAT = 15;
    localparam int CNT_ONE = 1;
`else
    localparam int CNT_SAT = 0;
    localparam int CNT_ONE = 0;
`endif

    logic        clk;
    logic        rst_n;

    logic [3:0]  in_a, sclr_a, cclr_a, rise_a, fall_a, ev_a, lvl_a, st_a;
    logic [7:0]  mode_a;
    logic        irq_a;
    logic [63:0] cnt_a;

    logic [3:0]  in_b, sclr_b, cclr_b, rise_b, fall_b, ev_b, lvl_b, st_b;
    logic [7:0]  mode_b;
    logic        irq_b;
    logic [15:0] cnt_b;

    int n_checks;
    int n_pass;
    int r_cnt, f_cnt, e_cnt, ef_cnt;

    event_pulse_array #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .CNT_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in(in_a), .mode(mode_a),
        .status_clr(sclr_a), .cnt_clr(cclr_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .event_pulse(ev_a),
        .level(lvl_a), .status(st_a), .irq(irq_a), .event_cnt(cnt_a)
    );

    event_pulse_array #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_WIDTH(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .mode(mode_b),
        .status_clr(sclr_b), .cnt_clr(cclr_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .event_pulse(ev_b),
        .level(lvl_b), .status(st_b), .irq(irq_b), .event_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_a = 4'b0000; mode_a = 8'hFF; sclr_a = 4'b0000; cclr_a = 4'b0000;
        in_b = 4'b0000; mode_b = 8'b11_00_11_01; sclr_b = 4'b0000; cclr_b = 4'b0000;
        repeat (3) tick();

        check_eq("rst_level_a",  32'(lvl_a), 32'h0);
        check_eq("rst_status_a", 32'(st_a),  32'h0);
        check_eq("rst_irq_a",    32'(irq_a), 32'h0);
        check_eq("rst_cnt_a",    cnt_a[31:0], 32'h0);

        rst_n = 1'b1;
        tick();

        // Basic latency: rising edge on ch0, all modes 11
        in_a[0] = 1'b1;
        tick();
        check_eq("t1_e0_rise", 32'(rise_a), 32'h0);
        tick();
        check_eq("t1_e1_rise", 32'(rise_a), 32'h0);
        tick();
        check_eq("t1_e2_rise",   32'(rise_a), 32'h1);
        check_eq("t1_e2_event",  32'(ev_a),   32'h1);
        check_eq("t1_e2_level",  32'(lvl_a),  32'h1);
        check_eq("t1_e2_status", 32'(st_a),   32'h1);
        check_eq("t1_e2_irq",    32'(irq_a),  32'h0);
        tick();
        check_eq("t1_e3_rise",  32'(rise_a), 32'h0);
        check_eq("t1_e3_event", 32'(ev_a),   32'h0);
        check_eq("t1_e3_irq",   32'(irq_a),  32'h1);

        // Ch1 rising-only mode: both raw pulses fire, event only on rise
        mode_a = 8'b11_11_01_11;
        in_a[1] = 1'b1;
        r_cnt = 0; f_cnt = 0; e_cnt = 0; ef_cnt = 0;
        repeat (10) begin
            tick();
            r_cnt += int'(rise_a[1]);
            f_cnt += int'(fall_a[1]);
            e_cnt += int'(ev_a[1]);
        end
        in_a[1] = 1'b0;
        repeat (10) begin
            tick();
            r_cnt  += int'(rise_a[1]);
            f_cnt  += int'(fall_a[1]);
            ef_cnt += int'(ev_a[1]);
        end
        check_eq("t3_rise_count",     r_cnt,  32'd1);
        check_eq("t3_fall_count",     f_cnt,  32'd1);
        check_eq("t3_event_on_rise",  e_cnt,  32'd1);
        check_eq("t3_event_on_fall",  ef_cnt, 32'd0);
        check_eq("t3_status",         32'(st_a),  32'h3);
        check_eq("t3_level",          32'(lvl_a), 32'h1);

        // Status clear, set-wins collision, irq follow-up
        sclr_a = 4'b0011;
        tick();
        sclr_a = 4'b0000;
        check_eq("t4_clr_status", 32'(st_a),  32'h0);
        check_eq("t4_clr_irq_hi", 32'(irq_a), 32'h1);
        tick();
        check_eq("t4_clr_irq_lo", 32'(irq_a), 32'h0);
        in_a[2] = 1'b1;
        tick();
        tick();
        sclr_a = 4'b0100;
        tick();
        sclr_a = 4'b0000;
        check_eq("t4_set_wins_event",  32'(ev_a),  32'h4);
        check_eq("t4_set_wins_status", 32'(st_a),  32'h4);
        check_eq("t4_set_irq_lag",     32'(irq_a), 32'h0);
        tick();
        check_eq("t4_irq_up", 32'(irq_a), 32'h1);
        sclr_a = 4'b0100;
        tick();
        sclr_a = 4'b0000;
        check_eq("t4_late_clr_status", 32'(st_a),  32'h0);
        check_eq("t4_late_clr_irq",    32'(irq_a), 32'h1);
        tick();
        check_eq("t4_irq_down", 32'(irq_a), 32'h0);

        // FILTER_CYCLES=4: a 3-cycle glitch on ch1 is dropped
        in_b[1] = 1'b1;
        r_cnt = 0;
        repeat (3) begin
            tick();
            r_cnt += int'(rise_b[1]);
        end
        in_b[1] = 1'b0;
        repeat (4) begin
            tick();
            r_cnt += int'(rise_b[1]);
        end
        check_eq("t2_glitch_rise",  r_cnt, 32'd0);
        check_eq("t2_glitch_level", 32'(lvl_b), 32'h0);

        // Real rise on ch1 (mode 11) and ch2 (mode 00) lands at edge 5
        in_b[1] = 1'b1;
        in_b[2] = 1'b1;
        r_cnt = 0;
        repeat (5) begin
            tick();
            r_cnt += int'(rise_b != 4'b0000);
        end
        check_eq("t2_early_rise", r_cnt, 32'd0);
        tick();
        check_eq("t2_rise",   32'(rise_b), 32'h6);
        check_eq("t2_event",  32'(ev_b),   32'h2);
        check_eq("t2_level",  32'(lvl_b),  32'h6);
        check_eq("t2_status", 32'(st_b),   32'h2);
        tick();
        check_eq("t2_rise_one_cycle", 32'(rise_b), 32'h0);

        // 17 rising events on ch0 (mode 01) saturate the 4-bit counter
        e_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            in_b[0] = 1'b1;
            repeat (8) begin
                tick();
                e_cnt += int'(ev_b[0]);
            end
            in_b[0] = 1'b0;
            repeat (8) begin
                tick();
                e_cnt += int'(ev_b[0]);
            end
        end
        check_eq("t6_event_count", e_cnt, 32'd17);
        check_eq("t6_cnt_sat",     32'(cnt_b[3:0]),  CNT_SAT);
        check_eq("t6_cnt_mode00",  32'(cnt_b[11:8]), 32'h0);
        in_b[0] = 1'b1;
        repeat (5) tick();
        cclr_b[0] = 1'b1;
        tick();
        cclr_b[0] = 1'b0;
        check_eq("t6_clr_event", 32'(ev_b[0]),    32'h1);
        check_eq("t6_clr_cnt",   32'(cnt_b[3:0]), CNT_ONE);

        // Reset mid-filter with ch3 held high
        in_b = 4'b0000;
        repeat (8) tick();
        in_b[3] = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_level_b",  32'(lvl_b),  32'h0);
        check_eq("t5_rst_status_b", 32'(st_b),   32'h0);
        check_eq("t5_rst_irq_b",    32'(irq_b),  32'h0);
        check_eq("t5_rst_cnt_b",    32'(cnt_b),  32'h0);
        check_eq("t5_rst_pulses_b", 32'({rise_b, fall_b, ev_b}), 32'h0);
        check_eq("t5_rst_level_a",  32'(lvl_a),  32'h0);
        check_eq("t5_rst_status_a", 32'(st_a),   32'h0);
        check_eq("t5_rst_irq_a",    32'(irq_a),  32'h0);
        check_eq("t5_rst_cnt_a",    cnt_a[31:0], 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        r_cnt = 0;
        repeat (5) begin
            tick();
            r_cnt += int'(rise_b != 4'b0000);
        end
        check_eq("t5_early_rise", r_cnt, 32'd0);
        tick();
        check_eq("t5_rise",  32'(rise_b), 32'h8);
        check_eq("t5_level", 32'(lvl_b),  32'h8);
        tick();
        check_eq("t5_rise_one_cycle", 32'(rise_b), 32'h0);
        check_eq("t5_level_a",        32'(lvl_a),  32'h5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
